fetch_queue: RTL

Parametrised instruction fetch queue between the IF stage and the ID stage of the five-stage core. It decouples instruction fetch from decode stalls by buffering up to DEPTH fetched {pc, inst} pairs. It flushes on branch/redirect and discards the one in-flight inst_sram response that a flush leaves behind. It generalises the fixed single-register IF→ID handoff into a configurable-depth, handshaked buffer.

---
 rtl/fetch_queue_pkg.sv | 27 ++
 rtl/fetch_queue_mem.sv | 27 ++
 rtl/fetch_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared sizing macros and helpers for the IF->ID fetch queue.
// The optional zero-latency bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif
`ifndef FQ_ENTRY_WD
`define FQ_ENTRY_WD (PC_W+INST_W)
`endif

package fetch_queue_pkg;

    localparam int FQ_DEFAULT_DEPTH = `FQ_DEPTH;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // A simultaneous store and pop leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic store, input logic pop);
        if (store && !pop) return CNT_INC;
        if (pop && !store) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x WIDTH register array for the fetch queue: one write port, one async read port.
// Built identically with or without FETCH_QUEUE_BYPASS_EN.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array is deliberately not reset; validity is tracked by count, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Handshaked IF->ID instruction fetch queue with flush and post-flush response drop.
// Define FETCH_QUEUE_BYPASS_EN for a combinational push->pop path when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    parameter int PC_W = 32,
    parameter int INST_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [INST_W-1:0] push_inst,
    input  logic              fetch_pending,
    input  logic              flush,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [PC_W-1:0]   pop_pc,
    output logic [INST_W-1:0] pop_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENTRY_W = `FQ_ENTRY_WD;

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_drop_next;

    logic               w_full;
    logic               w_nonempty;
    logic               w_push_fire;
    logic               w_bypass;
    logic               w_store;
    logic               w_pop_stored;
    logic [ENTRY_W-1:0] w_head_entry;

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_nonempty   = (r_count != '0);
    assign push_ready   = ~w_full | r_drop_next;
    assign w_push_fire  = push_valid & push_ready;
    assign w_pop_stored = w_nonempty & pop_ready & ~flush;
    assign count        = r_count;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = ~w_nonempty & push_valid & pop_ready & ~flush & ~r_drop_next;
`else
    assign w_bypass = 1'b0;
`endif

    // Flushed, dropped and bypassed beats never touch the array.
    assign w_store = w_push_fire & ~flush & ~r_drop_next & ~w_bypass;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_store),
        .i_wr_addr (r_tail),
        .i_wr_data ({push_pc, push_inst}),
        .i_rd_addr (r_head),
        .o_rd_data (w_head_entry)
    );

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        pop_valid = 1'b0;
        pop_pc    = '0;
        pop_inst  = '0;
        if (w_bypass) begin
            pop_valid = 1'b1;
            pop_pc    = push_pc;
            pop_inst  = push_inst;
        end else if (w_nonempty && !flush) begin
            pop_valid          = 1'b1;
            {pop_pc, pop_inst} = w_head_entry;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_drop_next <= 1'b0;
        end else if (flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_drop_next <= r_drop_next | fetch_pending;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop_stored) begin
                r_head <= r_head + PTR_W'(1);
            end
            case (cnt_op(w_store, w_pop_stored))
                CNT_INC: r_count <= r_count + CNT_W'(1);
                CNT_DEC: r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // The in-flight response left over from a flush is swallowed here.
            if (r_drop_next && push_valid) begin
                r_drop_next <= 1'b0;
            end
        end
    end

endmodule
